// File: rtl/mpq_ram_sink.sv
// RAM model for the max-priority-queue write port: captures the write stream, then verifies the max-heap on done.
// Optional build macro MPQ_SINK_SEQ_CHECK_EN adds seq_err and enforces strictly sequential writes from 0.
module mpq_ram_sink #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RAM_valid,
    input  logic [AW-1:0] RAM_A,
    input  logic [DW-1:0] RAM_D,
    input  logic          done,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] count,
    output logic          checking,
    output logic          check_done,
    output logic          heap_ok,
    output logic [AW-1:0] err_idx,
`ifdef MPQ_SINK_SEQ_CHECK_EN
    output logic          seq_err,
`endif
    output logic          overflow
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, REPORT} state_t;

    state_t           state;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] written;
    logic [AW-1:0]    k;
    logic             done_q;
`ifdef MPQ_SINK_SEQ_CHECK_EN
    logic [AW-1:0]    seq_idx;
`endif

    logic          done_rise;
    logic          wr_in;
    logic          rd_in;
    logic [IW-1:0] wa;
    logic [IW-1:0] ki;
    logic [IW-1:0] pi;
    logic [AW-1:0] wa_next;
    logic          root_fail;
    logic          k_fail;
    logic          fail;
    logic          last;
    logic [AW-1:0] fail_idx;

    // Address decode and the single heap comparison performed at index k.
    always_comb begin
        done_rise = done & ~done_q;
        wr_in     = RAM_valid && (RAM_A < AW'(DEPTH));
        rd_in     = rd_addr < AW'(DEPTH);
        wa        = RAM_A[IW-1:0];
        wa_next   = RAM_A + AW'(1);
        ki        = k[IW-1:0];
        pi        = IW'((k - AW'(1)) >> 1);
        root_fail = (k == AW'(1)) && (count != '0) && !written[0];
        k_fail    = (count > AW'(1)) && (!written[ki] || (mem[ki] > mem[pi]));
        fail      = root_fail || k_fail;
        fail_idx  = root_fail ? '0 : k;
        last      = (count <= AW'(1)) || (k == count - AW'(1));
    end

    // Storage array is never cleared; in-range writes land in any state.
    always_ff @(posedge clk) begin
        if (wr_in) begin
            mem[wa] <= RAM_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            done_q     <= 1'b1;
            k          <= '0;
            written    <= '0;
            count      <= '0;
            checking   <= 1'b0;
            check_done <= 1'b0;
            heap_ok    <= 1'b0;
            err_idx    <= '0;
            overflow   <= 1'b0;
            rd_data    <= '0;
`ifdef MPQ_SINK_SEQ_CHECK_EN
            seq_err    <= 1'b0;
            seq_idx    <= '0;
`endif
        end else begin
            done_q  <= done;
            rd_data <= rd_in ? mem[rd_addr[IW-1:0]] : '0;

            case (state)
                IDLE, REPORT: begin
                    if (RAM_valid) begin
                        // Any write here opens a new frame and wipes the previous verdict.
                        check_done <= 1'b0;
                        heap_ok    <= 1'b0;
                        err_idx    <= '0;
                        overflow   <= 1'b0;
                        written    <= wr_in ? (DEPTH'(1) << wa) : '0;
                        count      <= wr_in ? wa_next : '0;
`ifdef MPQ_SINK_SEQ_CHECK_EN
                        seq_err    <= wr_in && (RAM_A != '0);
                        seq_idx    <= RAM_A;
`endif
                        state      <= CAPTURE;
                    end else if ((state == IDLE) && done_rise) begin
                        check_done <= 1'b1;
                        heap_ok    <= 1'b1;
                        err_idx    <= '0;
                        count      <= '0;
                        state      <= REPORT;
                    end
                end
                CAPTURE: begin
                    if (wr_in) begin
                        written[wa] <= 1'b1;
                        if (wa_next > count) begin
                            count <= wa_next;
                        end
`ifdef MPQ_SINK_SEQ_CHECK_EN
                        if ((RAM_A != count) && !seq_err) begin
                            seq_err <= 1'b1;
                            seq_idx <= RAM_A;
                        end
`endif
                    end
                    if (done_rise) begin
                        k        <= AW'(1);
                        checking <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    // Late writes are stored but the walk keeps its frozen count.
                    if (wr_in) begin
                        written[wa] <= 1'b1;
                    end
                    if (fail || last) begin
                        checking   <= 1'b0;
                        check_done <= 1'b1;
                        heap_ok    <= !fail;
                        err_idx    <= fail ? fail_idx : '0;
`ifdef MPQ_SINK_SEQ_CHECK_EN
                        if (seq_err) begin
                            heap_ok <= 1'b0;
                            err_idx <= seq_idx;
                        end
`endif
                        state      <= REPORT;
                    end else begin
                        k <= k + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (RAM_valid && !wr_in) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/mpq_ram_sink.md
# mpq_ram_sink

Receiving end of the max-priority-queue RAM write port. It captures the `RAM_valid`/`RAM_A`/`RAM_D` write stream the queue emits during its WRITE command, stores it in a local array, and, on the rising edge of `done`, walks the captured array to confirm the max-heap property. It sits beside the queue in system and bench builds as the RAM model, and provides a random-read port for inspection.

## Interface
- `DEPTH`, 32: capture array entries; addresses `0..DEPTH-1` are valid.
- `AW`, 8: `RAM_A` / `rd_addr` width.
- `DW`, 8: `RAM_D` / `rd_data` width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `RAM_valid`  in  1  write strobe from the queue.
- `RAM_A`  in  AW  write address.
- `RAM_D`  in  DW  write data.
- `done`  in  1  queue finished; may stay high indefinitely.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  DW  `mem[rd_addr]`, registered, 1-cycle latency; 0 if `rd_addr >= DEPTH`.
- `count`  out  AW  captured entries, equal to highest written address + 1.
- `checking`  out  1  high while in CHECK.
- `check_done`  out  1  verdict valid; held until a new frame starts.
- `heap_ok`  out  1  verdict; meaningful only while `check_done` is high.
- `err_idx`  out  AW  first failing index; 0 when `heap_ok` is high.
- `overflow`  out  1  sticky: a write with `RAM_A >= DEPTH` occurred this frame.

## Operation
- States: IDLE, CAPTURE, CHECK, REPORT.
- All registered outputs reset to 0 when `rst` is sampled low. This includes `count`, `heap_ok`, `err_idx`, `check_done`, `overflow` and the `written` bitmap. The contents of `mem` are not cleared.
- `done` is edge-detected with a `done_q` register. Only a 0→1 transition starts a check.
- IDLE/REPORT, on `RAM_valid`: start a new frame.
  - Clear `check_done`, `heap_ok`, `err_idx`, `overflow` and `written`.
  - Set `count` to 0, then perform the write.
  - Go to CAPTURE.
- CAPTURE, on `RAM_valid` with `RAM_A < DEPTH`:
  - `mem[RAM_A] <= RAM_D`.
  - Set `written[RAM_A]`.
  - `count <= max(count, RAM_A+1)`.
- Any state, `RAM_valid` with `RAM_A >= DEPTH`: drop the write and set `overflow`.
- CAPTURE, on a `done` rising edge: go to CHECK with `k = 1`.
  - If the same cycle also carries `RAM_valid`, the write is committed first.
- A `done` edge in IDLE (no writes seen): go straight to REPORT with `heap_ok = 1` and `count = 0`.
- CHECK performs one comparison per cycle at index `k`, with `p = (k-1) >> 1`:
  - Fail if `written[k] == 0` (hole in the array).
  - Fail if `mem[k] > mem[p]`. Equal values pass.
  - Also fail at `k = 0` if `count >= 1` and `written[0] == 0`. This is checked in the first CHECK cycle, together with `k = 1`.
  - On failure: `heap_ok <= 0`, `err_idx <= k` (0 for the root hole), go to REPORT.
  - If `k == count-1` (or `count <= 1`) and there is no failure: `heap_ok <= 1`, go to REPORT.
  - Otherwise `k <= k + 1`.
- `overflow` does not by itself fail `heap_ok`.
- REPORT: `check_done = 1`. Stay until the next `RAM_valid`.
- `RAM_valid` while in CHECK: the write is committed, but the check continues on the current `count`. The result is undefined for that index.

## Timing
- Write capture: `mem` is updated at the edge where `RAM_valid` is sampled. `rd_data` reflects it 2 edges later if `rd_addr` is already set.
- A `done` rise is sampled at edge E0, and CHECK is entered after E0.
- Passing check: `check_done` is high after edge E0 + max(count-1, 1).
- Failing check: `check_done` is high after edge E0 + j, where j is the 1-based comparison cycle that failed.
- `checking` is high exactly during the CHECK cycles.
- Reset mid-CHECK: the next cycle is IDLE, all flags are 0 and no verdict is produced.

## Configuration
- `MPQ_SINK_SEQ_CHECK_EN`
  - Defined: each captured write must have `RAM_A == count`, i.e. strictly sequential from 0. A violating write is still stored, but sets a sticky `seq_err` output (1 bit, reset 0, cleared at frame start), and the final verdict forces `heap_ok = 0` with `err_idx` = first offending address.
  - Undefined: the `seq_err` port is absent and any write order is accepted; only holes and the heap order are checked.

## Test plan
- Write 9,7,8,3,5 at addresses 0..4, then raise `done` → `count=5`, `check_done` 4 cycles after the edge, `heap_ok=1`, `err_idx=0`.
- Write 9,7,8,3,12 at 0..4, then `done` → `heap_ok=0`, `err_idx=4`, `check_done` 4 cycles after the edge.
- Write addresses 0,1,3 only, then `done` → `count=4`, `heap_ok=0`, `err_idx=2` (hole).
- Write `RAM_A=40` with 0x55, then 0..1 = 6,2, then `done` → `overflow=1`, `heap_ok=1`, `count=2`.
- Hold `done` high after the verdict, then start a new frame with a write 0=1 → `check_done` clears, and no new check runs until `done` falls and rises again.
- Pull `rst` low for 1 cycle in the middle of CHECK → all outputs 0 on the next cycle; with `MPQ_SINK_SEQ_CHECK_EN`, writes 0,2 set `seq_err=1` and `err_idx=2`.
